// File: rtl/neuron_mac_ctrl.sv
// neuron_mac_ctrl
// Initiator-side controller for one neuron in a layer of the shared-resource
// NN fabric. It reads NumInputs activation/weight pairs through the shared RAM
// arbiters, multiplies each pair on the shared fixed-point multiplier, keeps a
// wide signed dot-product accumulator, and writes one saturated output
// activation to address NeuronInstance.
//
// Ports:
//   clk_i, reset_i           clock, synchronous active-low reset
//   start_i / done_o         level start; done held until start_i falls
//   busy_o                   high outside IDLE and DONE
//   in_actv_*                activation RAM: req/grant, addr = k, read data
//   wgt_*                    weight RAM: req/grant, addr = NeuronInstance*NumInputs + k
//   out_actv_*               output RAM: req/grant, addr = NeuronInstance, we, data
//   mult_*                   multiplier: req/grant, start pulse, operands, status, product
//
// Build option: define NEURON_RELU_EN to clamp a negative result to zero
// before it is written.
module neuron_mac_ctrl #(
    parameter int NumInputs      = 49,
    parameter int DataWidth      = 8,
    parameter int FpWidth        = 4,
    parameter int NeuronInstance = 0,
    parameter int AddrWidth      = 16,
    parameter int AccWidth       = DataWidth + $clog2(NumInputs) + 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 in_actv_req_o,
    input  logic                 in_actv_grant_i,
    output logic [AddrWidth-1:0] in_actv_addr_o,
    output logic                 in_actv_we_o,
    input  logic [DataWidth-1:0] in_actv_din_i,
    output logic                 wgt_req_o,
    input  logic                 wgt_grant_i,
    output logic [AddrWidth-1:0] wgt_addr_o,
    output logic                 wgt_we_o,
    input  logic [DataWidth-1:0] wgt_din_i,
    output logic                 out_actv_req_o,
    input  logic                 out_actv_grant_i,
    output logic [AddrWidth-1:0] out_actv_addr_o,
    output logic                 out_actv_we_o,
    output logic [DataWidth-1:0] out_actv_dout_o,
    output logic                 mult_req_o,
    input  logic                 mult_grant_i,
    output logic                 mult_start_o,
    output logic [DataWidth-1:0] mult_a_o,
    output logic [DataWidth-1:0] mult_b_o,
    input  logic                 mult_done_i,
    input  logic                 mult_valid_i,
    input  logic                 mult_ovf_i,
    input  logic [DataWidth-1:0] mult_result_i
);

    localparam int KW = (NumInputs > 1) ? $clog2(NumInputs) : 1;
    localparam logic [KW-1:0]        KLast   = KW'(NumInputs - 1);
    localparam logic [AddrWidth-1:0] WgtBase = AddrWidth'(NeuronInstance * NumInputs);
    localparam logic [AddrWidth-1:0] OutAddr = AddrWidth'(NeuronInstance);
    localparam logic [DataWidth-1:0] DataMax = {1'b0, {(DataWidth-1){1'b1}}};
    localparam logic [DataWidth-1:0] DataMin = ~DataMax;
    localparam logic signed [AccWidth-1:0] AccMax =
        AccWidth'((32'sd1 <<< (DataWidth-1)) - 32'sd1);
    localparam logic signed [AccWidth-1:0] AccMin = ~AccMax;

    // The Q format only matters to the multiplier; reject a format with no integer bits.
    if (FpWidth >= DataWidth) begin : g_bad_fp
        $error("FpWidth must be smaller than DataWidth");
    end

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ACT_REQ  = 4'd1,
        S_ACT_RD   = 4'd2,
        S_WGT_REQ  = 4'd3,
        S_WGT_RD   = 4'd4,
        S_MUL_REQ  = 4'd5,
        S_MUL_WAIT = 4'd6,
        S_ACC      = 4'd7,
        S_OUT_REQ  = 4'd8,
        S_DONE     = 4'd9
    } state_t;

    state_t                       state_q, state_d;
    logic [KW-1:0]                k_q, k_d;
    logic signed [AccWidth-1:0]   acc_q, acc_d;
    logic [DataWidth-1:0]         act_q, act_d;
    logic [DataWidth-1:0]         wgt_q, wgt_d;
    logic [DataWidth-1:0]         prod_s;
    logic [AccWidth-1:0]          prod_ext_s;
    logic [DataWidth-1:0]         sat_s;
    logic [DataWidth-1:0]         res_s;

    // State, index, accumulator and operand registers.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            act_q   <= '0;
            wgt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            act_q   <= act_d;
            wgt_q   <= wgt_d;
        end
    end

    // Product selection: an overflowing or invalid product saturates toward the sign of a*b.
    always_comb begin
        prod_s = mult_result_i;
        if (mult_ovf_i || !mult_valid_i) begin
            prod_s = (act_q[DataWidth-1] ^ wgt_q[DataWidth-1]) ? DataMin : DataMax;
        end else begin
            prod_s = mult_result_i;
        end
        prod_ext_s = {{(AccWidth-DataWidth){prod_s[DataWidth-1]}}, prod_s};
    end

    // Clamp the accumulator to the signed data range, then apply the optional ReLU.
    always_comb begin
        sat_s = acc_q[DataWidth-1:0];
        if (acc_q > AccMax) begin
            sat_s = DataMax;
        end else if (acc_q < AccMin) begin
            sat_s = DataMin;
        end else begin
            sat_s = acc_q[DataWidth-1:0];
        end
`ifdef NEURON_RELU_EN
        res_s = sat_s[DataWidth-1] ? {DataWidth{1'b0}} : sat_s;
`else
        res_s = sat_s;
`endif
    end

    // Next-state logic for the per-input read/multiply/accumulate sequence.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        act_d   = act_q;
        wgt_d   = wgt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ACT_REQ;
                    k_d     = '0;
                    acc_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACT_REQ: begin
                if (in_actv_grant_i) state_d = S_ACT_RD;
                else                 state_d = S_ACT_REQ;
            end
            S_ACT_RD: begin
                act_d   = in_actv_din_i;
                state_d = S_WGT_REQ;
            end
            S_WGT_REQ: begin
                if (wgt_grant_i) state_d = S_WGT_RD;
                else             state_d = S_WGT_REQ;
            end
            S_WGT_RD: begin
                wgt_d   = wgt_din_i;
                state_d = S_MUL_REQ;
            end
            S_MUL_REQ: begin
                if (mult_grant_i) state_d = S_MUL_WAIT;
                else              state_d = S_MUL_REQ;
            end
            S_MUL_WAIT: begin
                if (mult_done_i) begin
                    acc_d   = acc_q + $signed(prod_ext_s);
                    state_d = S_ACC;
                end else begin
                    state_d = S_MUL_WAIT;
                end
            end
            S_ACC: begin
                if (k_q == KLast) begin
                    state_d = S_OUT_REQ;
                end else begin
                    k_d     = k_q + {{(KW-1){1'b0}}, 1'b1};
                    state_d = S_ACT_REQ;
                end
            end
            S_OUT_REQ: begin
                if (out_actv_grant_i) state_d = S_DONE;
                else                  state_d = S_OUT_REQ;
            end
            S_DONE: begin
                if (!start_i) state_d = S_IDLE;
                else          state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode the state register; the one-cycle strobes fire only on a granted cycle.
    always_comb begin
        in_actv_req_o   = (state_q == S_ACT_REQ);
        wgt_req_o       = (state_q == S_WGT_REQ);
        mult_req_o      = (state_q == S_MUL_REQ);
        out_actv_req_o  = (state_q == S_OUT_REQ);
        in_actv_addr_o  = in_actv_req_o ? AddrWidth'(k_q) : '0;
        wgt_addr_o      = wgt_req_o ? (WgtBase + AddrWidth'(k_q)) : '0;
        out_actv_addr_o = out_actv_req_o ? OutAddr : '0;
        out_actv_dout_o = out_actv_req_o ? res_s : '0;
        mult_start_o    = mult_req_o && mult_grant_i;
        out_actv_we_o   = out_actv_req_o && out_actv_grant_i;
        in_actv_we_o    = 1'b0;
        wgt_we_o        = 1'b0;
        mult_a_o        = act_q;
        mult_b_o        = wgt_q;
        done_o          = (state_q == S_DONE);
        busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
    end

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
module tb_neuron_mac_ctrl;

    localparam int NI      = 3;
    localparam int NINST   = 2;
    localparam int MUL_LAT = 2;

    logic        clk;
    logic        reset_i;
    logic        start_i;
    logic        done_o, busy_o;
    logic        in_actv_req_o, in_actv_grant_i, in_actv_we_o;
    logic [15:0] in_actv_addr_o;
    logic [7:0]  in_actv_din_i;
    logic        wgt_req_o, wgt_grant_i, wgt_we_o;
    logic [15:0] wgt_addr_o;
    logic [7:0]  wgt_din_i;
    logic        out_actv_req_o, out_actv_grant_i, out_actv_we_o;
    logic [15:0] out_actv_addr_o;
    logic [7:0]  out_actv_dout_o;
    logic        mult_req_o, mult_grant_i, mult_start_o;
    logic [7:0]  mult_a_o, mult_b_o;
    logic        mult_done_i, mult_valid_i, mult_ovf_i;
    logic [7:0]  mult_result_i;

    int tests  = 0;
    int failed = 0;
    int starts = 0;

    logic [7:0]  act_mem [0:3];
    logic [7:0]  wgt_mem [0:15];
    logic [23:0] exp_q [$];          // {addr, data}
    int          mcnt;
    logic [7:0]  ma, mb;
    logic        prev_start;

    neuron_mac_ctrl #(.NumInputs(NI), .NeuronInstance(NINST)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
        .done_o(done_o), .busy_o(busy_o),
        .in_actv_req_o(in_actv_req_o), .in_actv_grant_i(in_actv_grant_i),
        .in_actv_addr_o(in_actv_addr_o), .in_actv_we_o(in_actv_we_o),
        .in_actv_din_i(in_actv_din_i),
        .wgt_req_o(wgt_req_o), .wgt_grant_i(wgt_grant_i),
        .wgt_addr_o(wgt_addr_o), .wgt_we_o(wgt_we_o), .wgt_din_i(wgt_din_i),
        .out_actv_req_o(out_actv_req_o), .out_actv_grant_i(out_actv_grant_i),
        .out_actv_addr_o(out_actv_addr_o), .out_actv_we_o(out_actv_we_o),
        .out_actv_dout_o(out_actv_dout_o),
        .mult_req_o(mult_req_o), .mult_grant_i(mult_grant_i),
        .mult_start_o(mult_start_o), .mult_a_o(mult_a_o), .mult_b_o(mult_b_o),
        .mult_done_i(mult_done_i), .mult_valid_i(mult_valid_i),
        .mult_ovf_i(mult_ovf_i), .mult_result_i(mult_result_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Ideal Q4.4 multiply: returns {ovf, product[7:0]}.
    function automatic logic [8:0] q44_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        logic ovf;
        p   = int'($signed(a)) * int'($signed(b));
        p   = p >>> 4;
        ovf = (p > 127) || (p < -128);
        return {ovf, p[7:0]};
    endfunction

    // Synchronous RAM models: address sampled on a granted cycle, data the next cycle.
    always @(posedge clk) begin
        if (in_actv_req_o && in_actv_grant_i) in_actv_din_i <= act_mem[in_actv_addr_o[1:0]];
        if (wgt_req_o && wgt_grant_i)         wgt_din_i     <= wgt_mem[wgt_addr_o[3:0]];
    end

    // Multiplier model with MUL_LAT cycles of latency and a one-cycle done pulse.
    always @(posedge clk) begin
        logic [8:0] r;
        if (!reset_i) begin
            mcnt        <= 0;
            mult_done_i <= 1'b0;
        end else if (mult_start_o) begin
            mcnt        <= MUL_LAT;
            ma          <= mult_a_o;
            mb          <= mult_b_o;
            mult_done_i <= 1'b0;
        end else if (mcnt == 1) begin
            r             = q44_mul(ma, mb);
            mcnt          <= 0;
            mult_done_i   <= 1'b1;
            mult_ovf_i    <= r[8];
            mult_result_i <= r[7:0];
        end else begin
            if (mcnt > 1) mcnt <= mcnt - 1;
            mult_done_i <= 1'b0;
        end
    end

    // Monitor: scoreboard for output writes plus multiplier start-pulse rules.
    always @(negedge clk) begin
        logic [23:0] e;
        if (out_actv_we_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {out_actv_addr_o, out_actv_dout_o}, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", out_actv_addr_o, e[23:8]);
                chk("write_data", out_actv_dout_o, e[7:0]);
            end
        end
        if (mult_start_o) begin
            starts++;
            chk("start_with_grant", mult_grant_i, 1'b1);
            chk("start_not_pending", {(mcnt != 0), mult_done_i}, 2'b00);
            chk("start_one_cycle", prev_start, 1'b0);
        end
        prev_start = mult_start_o;
    end

    task automatic load(input logic [7:0] a0, a1, a2, w0, w1, w2);
        act_mem[0] = a0; act_mem[1] = a1; act_mem[2] = a2;
        wgt_mem[NINST*NI+0] = w0; wgt_mem[NINST*NI+1] = w1; wgt_mem[NINST*NI+2] = w2;
    endtask

    task automatic begin_run(input logic [7:0] exp_data);
        exp_q.push_back({16'(NINST), exp_data});
        starts  = 0;
        start_i = 1'b1;
    endtask

    task automatic finish_run(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!done_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"}, done_o, 1'b1);
        chk({nm, "_written"}, 64'(exp_q.size()), 64'd0);
        chk({nm, "_start_count"}, 64'(starts), 64'(NI));
        @(negedge clk);
        chk({nm, "_done_held"}, {done_o, busy_o}, 2'b10);
        start_i = 1'b0;
        @(negedge clk);
        chk({nm, "_done_drop"}, {done_o, busy_o}, 2'b00);
        exp_q.delete();
    endtask

    initial begin
        int n;
        logic [7:0] relu_exp;
        reset_i = 1'b0; start_i = 1'b0;
        in_actv_grant_i = 1'b1; wgt_grant_i = 1'b1;
        out_actv_grant_i = 1'b1; mult_grant_i = 1'b1;
        mult_valid_i = 1'b1; mult_ovf_i = 1'b0; mult_result_i = 8'h00;
        mult_done_i = 1'b0; in_actv_din_i = 8'h00; wgt_din_i = 8'h00;
        prev_start = 1'b0;
        for (int i = 0; i < 16; i++) wgt_mem[i] = 8'h00;
        for (int i = 0; i < 4; i++)  act_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {busy_o, done_o, in_actv_req_o, wgt_req_o, out_actv_req_o,
                           mult_req_o, mult_start_o, out_actv_we_o, in_actv_we_o, wgt_we_o}, 10'd0);
        chk("reset_addr", {in_actv_addr_o, wgt_addr_o, out_actv_addr_o}, 48'd0);
        chk("reset_data", {out_actv_dout_o, mult_a_o, mult_b_o}, 24'd0);
        reset_i = 1'b1;
        @(negedge clk);

        // 1.0*0.5 + 2.0*0.5 + (-1.0)*1.0 = 0.5
        load(8'h10, 8'h20, 8'hF0, 8'h08, 8'h08, 8'h10);
        begin_run(8'h08);
        finish_run("basic");

        // Every product overflows positive: 3*0x7F saturates to 0x7F.
        load(8'h70, 8'h70, 8'h70, 8'h70, 8'h70, 8'h70);
        begin_run(8'h7F);
        finish_run("ovf_pos");

        // Every product overflows negative: 3*0x80 saturates to 0x80.
        load(8'h70, 8'h70, 8'h70, 8'h90, 8'h90, 8'h90);
        begin_run(8'h80);
        finish_run("ovf_neg");

        // Weight grant withheld 5 cycles on input 1.
        load(8'h10, 8'h20, 8'hF0, 8'h08, 8'h08, 8'h10);
        begin_run(8'h08);
        n = 0;
        @(negedge clk);
        while (!(wgt_req_o && wgt_addr_o == 16'(NINST*NI+1)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached", wgt_addr_o, 16'(NINST*NI+1));
        wgt_grant_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", {wgt_req_o, wgt_addr_o, mult_start_o, mult_req_o},
                {1'b1, 16'(NINST*NI+1), 1'b0, 1'b0});
        end
        wgt_grant_i = 1'b1;
        finish_run("stall");

        // -1.0 * 0.5 = -0.5
`ifdef NEURON_RELU_EN
        relu_exp = 8'h00;
`else
        relu_exp = 8'hF8;
`endif
        load(8'hF0, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00);
        begin_run(relu_exp);
        finish_run("negative");

        // Reset while waiting on the multiplier, then rerun the basic case.
        load(8'h10, 8'h20, 8'hF0, 8'h08, 8'h08, 8'h10);
        start_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (mcnt == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mulwait_reached", {busy_o, (mcnt != 0)}, 2'b11);
        reset_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_reset", {busy_o, done_o, in_actv_req_o, wgt_req_o, out_actv_req_o,
                             mult_req_o, mult_start_o, out_actv_we_o}, 8'd0);
        @(negedge clk);
        reset_i = 1'b1;
        repeat (4) @(negedge clk);
        begin_run(8'h08);
        finish_run("restart");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
